// File: rtl/sccb_slave_model.sv
// SCCB/I2C register-port responder: oversamples SCL/SDA, answers DEV_ADDR and
// decodes 16-bit-address / 8-bit-data accesses onto a simple register port.
module sccb_slave_model #(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int         FILT_LEN = 3
) (
  input  logic        clk_sys50m,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, ADDR_H, ACK_H, ADDR_L, ACK_L,
    WDATA, WACK, RDATA, RACK, IGNORE
  } state_t;

  // Index 0 = SCL, index 1 = SDA.
  logic [1:0]    r_s1, r_s2, r_filt, r_filt_d;
  logic [CW-1:0] r_cnt [2];

  always_ff @(posedge clk_sys50m) begin
    if (rst) begin
      r_s1     <= 2'b11;
      r_s2     <= 2'b11;
      r_filt   <= 2'b11;
      r_filt_d <= 2'b11;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_s1     <= {sda_in, scl_in};
      r_s2     <= r_s1;
      r_filt_d <= r_filt;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(FILT_LEN - 1)) begin
          r_filt[i] <= r_s2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;

  assign w_scl_rise = r_filt[0] & ~r_filt_d[0];
  assign w_scl_fall = ~r_filt[0] & r_filt_d[0];
  assign w_start    = ~r_filt[1] & r_filt_d[1] & r_filt[0];
  assign w_stop     = r_filt[1] & ~r_filt_d[1] & r_filt[0];

  state_t      r_state;
  logic [3:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        r_rw, r_acked;
  logic [1:0]  r_rd_pend;
  logic        r_sda_oe, r_we, r_re, r_busy;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;

  assign w_byte = {r_shift[6:0], r_filt[1]};

  always_ff @(posedge clk_sys50m) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_rw      <= 1'b0;
      r_acked   <= 1'b0;
      r_rd_pend <= '0;
      r_sda_oe  <= 1'b0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_busy    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_we <= 1'b0;
      r_re <= 1'b0;
      if (w_start) begin
        r_state   <= DEV;
        r_bitcnt  <= '0;
        r_busy    <= 1'b1;
        r_sda_oe  <= 1'b0;
        r_rd_pend <= '0;
      end else if (w_stop) begin
        r_state   <= IDLE;
        r_busy    <= 1'b0;
        r_sda_oe  <= 1'b0;
        r_rd_pend <= '0;
      end else begin
        case (r_state)
          DEV, ADDR_H, ADDR_L, WDATA: begin
            if (w_scl_rise && r_bitcnt < 4'd8) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd7) begin
                case (r_state)
                  ADDR_H:  r_addr[15:8] <= w_byte;
                  ADDR_L:  r_addr[7:0]  <= w_byte;
                  WDATA: begin
                    r_wdata <= w_byte;
                    r_we    <= 1'b1;
                  end
                  default: ;
                endcase
              end
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              // ACK is driven from the SCL low phase after the 8th bit.
              r_bitcnt <= '0;
              case (r_state)
                DEV: begin
                  if (r_shift[7:1] == DEV_ADDR) begin
                    r_state  <= DEV_ACK;
                    r_sda_oe <= 1'b1;
                    r_rw     <= r_shift[0];
                  end else begin
                    r_state <= IGNORE;
                  end
                end
                ADDR_H:  begin r_state <= ACK_H; r_sda_oe <= 1'b1; end
                ADDR_L:  begin r_state <= ACK_L; r_sda_oe <= 1'b1; end
                default: begin r_state <= WACK;  r_sda_oe <= 1'b1; end
              endcase
            end
          end
          DEV_ACK, ACK_H, ACK_L, WACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_bitcnt <= '0;
              case (r_state)
                DEV_ACK: begin
                  if (r_rw) begin
                    r_state   <= RDATA;
                    r_re      <= 1'b1;
                    r_rd_pend <= 2'd1;
                  end else begin
                    r_state <= ADDR_H;
                  end
                end
                ACK_H:   r_state <= ADDR_L;
                ACK_L:   r_state <= WDATA;
                default: begin
                  r_state <= WDATA;
                  r_addr  <= r_addr + 16'd1;
                end
              endcase
            end
          end
          RDATA: begin
            // reg_rdata is sampled one cycle after the reg_re strobe.
            if (r_rd_pend == 2'd1) begin
              r_rd_pend <= 2'd2;
            end else if (r_rd_pend == 2'd2) begin
              r_shift   <= reg_rdata;
              r_sda_oe  <= ~reg_rdata[7];
              r_rd_pend <= '0;
              r_bitcnt  <= '0;
            end else if (w_scl_fall) begin
              if (r_bitcnt == 4'd7) begin
                r_sda_oe <= 1'b0;
                r_state  <= RACK;
                r_acked  <= 1'b0;
              end else begin
                r_sda_oe <= ~r_shift[6];
                r_shift  <= {r_shift[6:0], 1'b0};
                r_bitcnt <= r_bitcnt + 4'd1;
              end
            end
          end
          RACK: begin
            if (w_scl_rise) begin
              if (r_filt[1]) begin
                r_state <= IGNORE;
              end else begin
                r_acked <= 1'b1;
                r_addr  <= r_addr + 16'd1;
              end
            end else if (w_scl_fall && r_acked) begin
              r_state   <= RDATA;
              r_re      <= 1'b1;
              r_rd_pend <= 2'd1;
              r_acked   <= 1'b0;
            end
          end
          default: r_sda_oe <= 1'b0;
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;
  assign busy      = r_busy;

endmodule

// File: doc/sccb_slave_model.md
# sccb_slave_model

Synthesizable SCCB/I2C responder that answers the camera-configuration master on the same two-wire bus. It oversamples SCL/SDA on the 50 MHz system clock, acknowledges device ID 0x78/0x79, and decodes the OV5640 16-bit-address, 8-bit-data register protocol. Decoded accesses are presented on a simple register port. It stands in for the sensor in loopback and on-board bring-up, so master writes can be checked and read-back data (`riic_data`) exercised.

## Interface
- `DEV_ADDR`, 7'h3C: 7-bit device address; write ID 0x78, read ID 0x79.
- `FILT_LEN`, 3: consecutive identical samples required before a filtered SCL/SDA level changes.

- `clk_sys50m` in 1: system clock. The block has one clock.
- `rst` in 1: reset, synchronous and active-high.
- `scl_in` in 1: bus SCL, asynchronous.
- `sda_in` in 1: bus SDA, asynchronous.
- `sda_oe` out 1: 1 = pull SDA low (open-drain); 0 = release.
- `reg_addr` out 16: register pointer.
- `reg_wdata` out 8: write data, valid while `reg_we` = 1.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read request.
- `reg_rdata` in 8: read data; must be valid the cycle after `reg_re`.
- `busy` out 1: high from START detection to STOP detection.

## Operation
- **Input conditioning**
  - 2-FF synchronizer per line, then a `FILT_LEN` glitch filter.
  - Filter registers reset to 1 (idle bus).
  - All decoding uses filtered levels and one-cycle edge pulses derived from them.
- **Bus conditions**
  - START = filtered SDA fall while filtered SCL = 1.
  - STOP = filtered SDA rise while filtered SCL = 1.
  - START from any state, including repeated start, goes to DEV with the bit counter cleared.
  - STOP from any state goes to IDLE.
- **Bit timing**
  - Received bits are shifted MSB first on filtered SCL rise.
  - Slave SDA changes only in the cycle after a filtered SCL fall.
- **States:** IDLE, DEV, DEV_ACK, ADDR_H, ACK_H, ADDR_L, ACK_L, WDATA, WACK, RDATA, RACK, IGNORE.
- **DEV**
  - After 8 bits, compare ID[7:1] with `DEV_ADDR`.
  - Mismatch: go to IGNORE, no ACK.
  - Match and ID[0] = 0: DEV_ACK, then ADDR_H.
  - Match and ID[0] = 1: DEV_ACK, then RDATA.
- **Address phase**
  - ADDR_H loads `reg_addr[15:8]`; ADDR_L loads `reg_addr[7:0]`.
  - Each byte is ACKed.
  - A STOP after ACK_L (2-phase write) only sets the pointer.
- **WDATA**
  - Byte complete: `reg_wdata` = byte and `reg_we` = 1 for one cycle.
  - Then ACK.
  - `reg_addr` increments (16-bit wrap, 0xFFFF → 0x0000) on the SCL fall ending WACK.
  - Further bytes repeat WDATA.
- **RDATA**
  - `reg_re` pulses on the SCL fall ending DEV_ACK (or RACK).
  - `reg_rdata` is latched the next cycle.
  - Bits are driven MSB first: `sda_oe` = ~bit.
  - After bit 0 the line is released for RACK, and the master ACK/NACK is sampled on SCL rise.
  - ACK (0): `reg_addr` increments and the next byte is read.
  - NACK (1): go to IGNORE.
- **Pointer retention:** `reg_addr` persists across transactions and is cleared only by `rst`.
- **IGNORE:** `sda_oe` = 0 until START or STOP.

## Timing
- **Reset values:** `sda_oe`, `reg_we`, `reg_re`, `busy` = 0; `reg_addr`, `reg_wdata` = 0; state = IDLE.
- **Mid-frame reset:** reset is the same; SDA is released the cycle after `rst`.
- **Input latency:** pin to filtered level = 2 + `FILT_LEN` cycles. START/STOP detection follows 1 cycle later.
- **ACK window**
  - `sda_oe` = 1 from the cycle after the 8th-bit SCL fall until the cycle after the 9th-bit SCL fall.
- **Write strobe:** `reg_we` is asserted the cycle after the 8th-bit SCL rise of a data byte.
- **Read path:** `reg_re` to first driven bit is 2 cycles. The slave releases SDA 1 cycle after the SCL fall following bit 0.
- **Master timing requirement:** SCL low and high periods must each be ≥ `FILT_LEN` + 4 clocks. The master at 50 MHz with 100–400 kHz SCL meets this.
- **Coincident events:** START and STOP detected in the same cycle is impossible (single SDA edge). A STOP during an ACK window releases SDA next cycle.

## Test plan
- **Write:** START, 0x78, 0x30, 0x08, 0x82, STOP.
  - ACK on all 4 bytes.
  - One `reg_we` with `reg_addr` = 0x3008 and `reg_wdata` = 0x82.
  - `busy` falls after STOP.
- **Burst write:** 0x78, 0x48, 0x00, 0x11, 0x22.
  - Two strobes: (0x4800, 0x11), then (0x4801, 0x22).
- **Read:** write 0x78, 0x30, 0x0A, STOP; then START, 0x79; model returns 0x56; master NACKs; STOP.
  - `reg_re` with `reg_addr` = 0x300A.
  - 0x56 appears on SDA MSB first.
  - SDA is released after the NACK.
- **Wrong ID:** send 0x42.
  - SDA never pulled low (NACK).
  - No `reg_we`/`reg_re` until the next START.
- **Glitch rejection and wrap**
  - A 2-cycle SCL pulse in mid-byte is ignored.
  - Burst write starting at 0xFFFF wraps `reg_addr` to 0x0000.
- **Reset mid-ACK:** assert `rst` while `sda_oe` = 1.
  - `sda_oe` = 0 on the next cycle and state = IDLE.
  - A subsequent full write succeeds.
